ps2_scancode_collector: RTL and testbench
=========================================

PS2_SCANCODE_COLLECTOR -- requirements
Module: ps2_scancode_collector

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for ps2_clk/ps2_data.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100_000: clk cycles with no ps2_clk falling edge before an in-progress frame is aborted (1 ms at 100 MHz).
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1  asynchronous keyboard clock.
REQ-006 SHALL have port ps2_data  input  1  asynchronous keyboard data.
REQ-007 SHALL have port val_out  output  32  last four make codes; [7:0] newest, [31:24] oldest; feeds the 4-digit seven-segment controller.
REQ-008 SHALL have port code_valid  output  1  one-cycle pulse when val_out takes a new code.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on parity error, stop-bit error or timeout.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through SYNC_STAGES flops each, then detect falling edges of synced ps2_clk (prev 1, now 0).
REQ-011 SHALL sample synced ps2_data only on detected falling edges.
REQ-012 SHALL use frame FSM states IDLE, DATA, PARITY, STOP.
REQ-013 IDLE: edge with data 0 (start bit) -> DATA, bit count 0; edge with data 1 -> stay IDLE, no error.
REQ-014 DATA: shift in 8 bits LSB first; after the 8th edge -> PARITY.
REQ-015 PARITY: capture parity bit -> STOP; the 8 data bits plus parity SHALL have odd parity to pass.
REQ-016 STOP: on edge, stop=1 and parity ok -> byte accepted; otherwise frame_err pulse; either case -> IDLE.
REQ-017 SHALL keep a timeout counter, cleared on every falling edge and in IDLE; if it reaches TIMEOUT_CYCLES outside IDLE -> IDLE, partial byte discarded, frame_err pulse.
REQ-018 Edge and timeout in the same cycle: edge SHALL win; no timeout.
REQ-019 Accepted 8'hF0 SHALL set break_pending; no shift.
REQ-020 Accepted 8'hE0 SHALL be dropped; no shift; break_pending unchanged.
REQ-021 Any other accepted byte with break_pending=1 SHALL clear break_pending; no shift.
REQ-022 Any other accepted byte with break_pending=0 SHALL set val_out <= {val_out[23:0], byte} and pulse code_valid.
REQ-023 val_out and code_valid SHALL update in the cycle after the cycle in which the stop-bit edge is detected.
REQ-024 Repeated identical make codes (typematic) SHALL each shift in.
REQ-025 code_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-026 While reset_n=0 at a clk edge: FSM IDLE, bit count 0, shift byte 0, timeout counter 0, break_pending 0, val_out 32'h0000_0000 (all digits blank downstream), code_valid 0, frame_err 0.
REQ-027 Reset mid-frame SHALL discard the partial byte; the next start bit after release SHALL be received normally.
REQ-028 Synchronizer flops SHALL reset to 1 (bus idle) so release creates no false edge.

Structure
REQ-029 Package ps2_pkg SHALL hold the frame-state enum, BREAK_CODE 8'hF0, EXT_CODE 8'hE0 and DATA_BITS 8.
REQ-030 Sub-module ps2_frame_rx SHALL contain synchronizer, edge detect, frame FSM and timeout, outputting byte, byte_valid and frame_err; the top SHALL hold break/extended decode and the val_out shift register.

Verification
REQ-031 Frames 0x16, 0x1E, 0x26, 0x25 -> val_out 32'h161E_2625, four code_valid pulses, no frame_err.
REQ-032 From reset, frames 0x1C, 0xF0, 0x1C -> val_out 32'h0000_001C, one code_valid pulse.
REQ-033 Frames 0xE0, 0x75 -> val_out 32'h0000_0075; then 0xE0, 0xF0, 0x75 -> val_out unchanged, no pulses.
REQ-034 Frame 0x45 with wrong parity bit -> one frame_err pulse, val_out unchanged; next good 0x45 -> [7:0]=0x45.
REQ-035 Start bit plus 4 data bits, then ps2_clk idle TIMEOUT_CYCLES -> one frame_err pulse, FSM IDLE; following good 0x33 accepted.
REQ-036 reset_n low 2 cycles after the 5th data edge of a frame -> val_out 0, no pulses; next full frame 0x21 -> val_out 32'h0000_0021.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 scancode collector:
//   - frame_state_e : receiver frame FSM states
//   - byte_kind_e   : classification of an accepted scancode byte
//   - BREAK_CODE, EXT_CODE, DATA_BITS constants
//   - classify_byte : maps a received byte onto byte_kind_e
package ps2_pkg;

  localparam int         DATA_BITS  = 8;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  typedef enum logic [1:0] {
    KIND_MAKE  = 2'd0,
    KIND_BREAK = 2'd1,
    KIND_EXT   = 2'd2
  } byte_kind_e;

  function automatic byte_kind_e classify_byte(input logic [7:0] b);
    if (b == BREAK_CODE)    return KIND_BREAK;
    else if (b == EXT_CODE) return KIND_EXT;
    else                    return KIND_MAKE;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
// Synchronizes the PS/2 clock/data lines, detects falling edges of the
// keyboard clock and assembles 11-bit frames (start, 8 data LSB first,
// odd parity, stop). An in-progress frame is abandoned if the keyboard
// clock stops falling for TIMEOUT_CYCLES clk cycles.
// Ports:
//   clk, reset_n         system clock, synchronous active-low reset
//   ps2_clk, ps2_data    asynchronous keyboard lines
//   data_byte            last assembled data byte
//   byte_valid           strobe: good frame finished this cycle
//   frame_err            strobe: parity/stop error or timeout this cycle
// The strobes are combinational from registered state so the consumer can
// register the result on the same clk edge that closes the frame.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(DATA_BITS);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  frame_state_e           state;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   parity_bit;
  logic [TW-1:0]          to_cnt;

  logic                   stop_edge;
  logic                   frame_good;
  logic                   timeout_hit;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  // Synchronizers and edge history reset to the idle-high bus level, so
  // leaving reset with the lines idle never looks like a falling edge.
  // NOTE: every register here is assigned with <= so all flops sample the
  // pre-edge values; a blocking = would let later statements see new values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  // Odd parity over data + parity bit: XOR reduction is 1 for an odd count.
  assign stop_edge   = fall && (state == ST_STOP);
  assign frame_good  = data_s && (^{shift_reg, parity_bit});
  assign timeout_hit = !fall && (state != ST_IDLE) &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  assign data_byte  = shift_reg;
  assign byte_valid = stop_edge && frame_good;
  assign frame_err  = (stop_edge && !frame_good) || timeout_hit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
    end else if (fall) begin
      // A falling edge always clears the timeout, even in the cycle where
      // the counter would otherwise have expired.
      to_cnt <= '0;
      case (state)
        ST_IDLE: begin
          if (!data_s) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          shift_reg <= {data_s, shift_reg[DATA_BITS-1:1]};
          bit_cnt   <= bit_cnt + BW'(1);
          if (bit_cnt == BW'(DATA_BITS - 1)) state <= ST_PARITY;
        end
        ST_PARITY: begin
          parity_bit <= data_s;
          state      <= ST_STOP;
        end
        ST_STOP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end else if (state == ST_IDLE) begin
      to_cnt <= '0;
    end else if (timeout_hit) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      to_cnt    <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/ps2_scancode_collector.sv
// ps2_scancode_collector
// Receives PS/2 keyboard frames and keeps the last four make codes for a
// 4-digit seven-segment display. Break sequences (F0 xx) are swallowed and
// the extended prefix E0 is ignored.
// Ports:
//   clk, reset_n        system clock, synchronous active-low reset
//   ps2_clk, ps2_data   asynchronous keyboard lines
//   val_out[31:0]       last four make codes, [7:0] newest, [31:24] oldest
//   code_valid          one-cycle pulse when val_out takes a new code
//   frame_err           one-cycle pulse on parity/stop error or timeout
module ps2_scancode_collector
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] val_out,
  output logic        code_valid,
  output logic        frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic       break_pending;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_byte (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_err)
  );

  // rx_valid and rx_err come from mutually exclusive stop-bit outcomes (or a
  // timeout, which cannot coincide with a stop edge), so the two output
  // pulses never overlap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      val_out       <= 32'h0000_0000;
      break_pending <= 1'b0;
      code_valid    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= rx_err;
      if (rx_valid) begin
        case (classify_byte(rx_byte))
          KIND_BREAK: break_pending <= 1'b1;
          KIND_EXT:   ;
          default: begin
            if (break_pending) begin
              // Key-release code: consume it without touching the display.
              break_pending <= 1'b0;
            end else begin
              val_out    <= {val_out[23:0], rx_byte};
              code_valid <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_collector.sv
// tb_ps2_scancode_collector
// Table-driven frames, hand-written corner sequences (timeout, reset in the
// middle of a frame, idle clock pulse) and randomized frames checked against
// a queue-based model of the last four make codes.
module tb_ps2_scancode_collector;

  localparam int TIMEOUT = 100;
  localparam int HALF    = 10;   // clk cycles per half ps2_clk period
  localparam int GAP     = 20;   // clk cycles between frames

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] val_out;
  logic        code_valid;
  logic        frame_err;

  int n_cmp = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  ps2_scancode_collector #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .val_out   (val_out),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) valid_cnt++;
    if (frame_err) err_cnt++;
    if (code_valid && frame_err) both_cnt++;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Full frame. v_at/e_at sample the outputs exactly three clk cycles after
  // the stop-bit falling edge (two synchronizer flops, one output register).
  task automatic send_frame(input logic [7:0] d, input bit bad_par,
                            input bit bad_stop, output logic v_at,
                            output logic e_at, output int nv, output int ne);
    int v0;
    int e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad_par);
    ps2_data = ~bad_stop;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    v_at = code_valid;
    e_at = frame_err;
    repeat (HALF - 3) @(negedge clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
    nv = valid_cnt - v0;
    ne = err_cnt - e0;
  endtask

  typedef struct {
    bit          do_reset;
    logic [7:0]  data;
    bit          bad_par;
    bit          bad_stop;
    logic        exp_valid;
    logic        exp_err;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs[$];

  // Reference model: the display shows the last four make codes in order.
  logic [7:0] make_q[$];
  bit         m_break;

  function automatic logic [31:0] model_val();
    logic [31:0] v;
    v = 32'h0;
    foreach (make_q[i]) v = (v << 8) | 32'(make_q[i]);
    return v;
  endfunction

  initial begin
    logic v_at;
    logic e_at;
    int   nv;
    int   ne;
    int   v0;
    int   e0;
    logic [7:0] d;

    // Reset state, checked while reset is still applied.
    repeat (3) @(negedge clk);
    check("reset val_out", val_out, 32'h0);
    check("reset code_valid", {31'h0, code_valid}, 32'h0);
    check("reset frame_err", {31'h0, frame_err}, 32'h0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    vecs.push_back('{1'b1, 8'h16, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0016});
    vecs.push_back('{1'b0, 8'h1E, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_161E});
    vecs.push_back('{1'b0, 8'h26, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0016_1E26});
    vecs.push_back('{1'b0, 8'h25, 1'b0, 1'b0, 1'b1, 1'b0, 32'h161E_2625});
    vecs.push_back('{1'b0, 8'h1D, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1E26_251D});
    vecs.push_back('{1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_001C});
    vecs.push_back('{1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_001C});
    vecs.push_back('{1'b0, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_001C});
    vecs.push_back('{1'b1, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000});
    vecs.push_back('{1'b0, 8'h75, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0075});
    vecs.push_back('{1'b0, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0075});
    vecs.push_back('{1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0075});
    vecs.push_back('{1'b0, 8'h75, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0075});
    vecs.push_back('{1'b0, 8'h45, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0075});
    vecs.push_back('{1'b0, 8'h45, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_7545});
    vecs.push_back('{1'b0, 8'h12, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_7545});
    vecs.push_back('{1'b0, 8'h1D, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0075_451D});
    vecs.push_back('{1'b0, 8'h1D, 1'b0, 1'b0, 1'b1, 1'b0, 32'h7545_1D1D});
    vecs.push_back('{1'b0, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h7545_1D1D});
    vecs.push_back('{1'b0, 8'h29, 1'b0, 1'b0, 1'b1, 1'b0, 32'h451D_1D29});

    foreach (vecs[i]) begin
      if (vecs[i].do_reset) do_reset();
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop,
                 v_at, e_at, nv, ne);
      check($sformatf("vec%0d val_out", i), val_out, vecs[i].exp_val);
      check($sformatf("vec%0d code_valid timing", i), {31'h0, v_at},
            {31'h0, vecs[i].exp_valid});
      check($sformatf("vec%0d frame_err timing", i), {31'h0, e_at},
            {31'h0, vecs[i].exp_err});
      check($sformatf("vec%0d code_valid count", i), 32'(nv),
            {31'h0, vecs[i].exp_valid});
      check($sformatf("vec%0d frame_err count", i), 32'(ne),
            {31'h0, vecs[i].exp_err});
    end

    // Timeout: start bit + 4 data bits, then the keyboard clock stops.
    do_reset();
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
    repeat (TIMEOUT / 2) @(negedge clk);
    check("timeout not early", 32'(err_cnt - e0), 32'd0);
    repeat (2 * TIMEOUT) @(negedge clk);
    check("timeout frame_err count", 32'(err_cnt - e0), 32'd1);
    check("timeout code_valid count", 32'(valid_cnt - v0), 32'd0);
    check("timeout val_out", val_out, 32'h0);
    send_frame(8'h33, 1'b0, 1'b0, v_at, e_at, nv, ne);
    check("after timeout 0x33", val_out, 32'h0000_0033);
    check("after timeout pulse", 32'(nv), 32'd1);

    // Single clock pulse with data high while idle: ignored, no error.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bit(1'b1);
    repeat (2 * TIMEOUT) @(negedge clk);
    check("idle pulse errors", 32'(err_cnt - e0), 32'd0);
    send_frame(8'h34, 1'b0, 1'b0, v_at, e_at, nv, ne);
    check("idle pulse then 0x34", val_out, 32'h0000_3334);
    check("idle pulse total valid", 32'(valid_cnt - v0), 32'd1);

    // Reset two cycles after the 5th data edge of a frame.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_data = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * TIMEOUT) @(negedge clk);
    check("midframe reset val_out", val_out, 32'h0);
    check("midframe reset valid", 32'(valid_cnt - v0), 32'd0);
    check("midframe reset err", 32'(err_cnt - e0), 32'd0);
    send_frame(8'h21, 1'b0, 1'b0, v_at, e_at, nv, ne);
    check("after reset 0x21", val_out, 32'h0000_0021);
    check("after reset pulse", 32'(nv), 32'd1);

    // Randomized frames against the queue model.
    do_reset();
    make_q.delete();
    m_break = 1'b0;
    for (int n = 0; n < 40; n++) begin
      bit bp;
      bit bs;
      bit good;
      logic ev;
      case ($urandom_range(0, 7))
        0:       d = 8'hF0;
        1:       d = 8'hE0;
        default: d = 8'($urandom_range(0, 255));
      endcase
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 9) == 0);
      good = !bp && !bs;
      ev = 1'b0;
      if (good) begin
        if (d == 8'hF0) m_break = 1'b1;
        else if (d == 8'hE0) m_break = m_break;
        else if (m_break) m_break = 1'b0;
        else begin
          make_q.push_back(d);
          if (make_q.size() > 4) void'(make_q.pop_front());
          ev = 1'b1;
        end
      end
      send_frame(d, bp, bs, v_at, e_at, nv, ne);
      check($sformatf("rand%0d val_out (byte %h)", n, d), val_out, model_val());
      check($sformatf("rand%0d code_valid", n), 32'(nv), {31'h0, ev});
      check($sformatf("rand%0d frame_err", n), 32'(ne), {31'h0, !good});
    end

    check("code_valid/frame_err overlap", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
